// File: rtl/decode_stage_p.sv
// MISC-V decode stage: register file, instruction decode, ID-stage branch resolution,
// hazard detection and ID/EX register. Optional macro REGFILE_BYPASS_EN adds write-read bypass.
module decode_stage_p #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PC_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [15:0]       i_ir_in,
    input  logic [PC_W-1:0]   i_pc_in,
    input  logic [PC_W-1:0]   i_ipcp2,
    input  logic              i_id_valid,
    input  logic [2:0]        i_load_addr,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_rf_write,
    input  logic              i_fwd_sel1,
    input  logic              i_fwd_sel2,
    input  logic [DATA_W-1:0] i_fwd_data,
    input  logic              i_ex_stall,
    output logic              o_reg_write,
    output logic              o_alu_src,
    output logic              o_mem_write,
    output logic              o_mem_read,
    output logic              o_valid,
    output logic [2:0]        o_alu_op,
    output logic [1:0]        o_reg_store,
    output logic [PC_W-1:0]   o_opcp2,
    output logic [DATA_W-1:0] o_arg1,
    output logic [DATA_W-1:0] o_arg2,
    output logic [DATA_W-1:0] o_arg3,
    output logic [DATA_W-1:0] o_imm,
    output logic [2:0]        o_rs1,
    output logic [2:0]        o_rs2,
    output logic [2:0]        o_rd,
    output logic              o_stall_if,
    output logic              o_jump,
    output logic [PC_W-1:0]   o_new_pc
);

    localparam logic [3:0] OP_R   = 4'h0;
    localparam logic [3:0] OP_I   = 4'h1;
    localparam logic [3:0] OP_LW  = 4'h2;
    localparam logic [3:0] OP_SW  = 4'h3;
    localparam logic [3:0] OP_BEQ = 4'h4;
    localparam logic [3:0] OP_BNE = 4'h5;
    localparam logic [3:0] OP_JAL = 4'h6;

    typedef struct packed {
        logic              reg_write;
        logic              alu_src;
        logic              mem_write;
        logic              mem_read;
        logic              valid;
        logic [2:0]        alu_op;
        logic [1:0]        reg_store;
        logic [PC_W-1:0]   opcp2;
        logic [DATA_W-1:0] arg1;
        logic [DATA_W-1:0] arg2;
        logic [DATA_W-1:0] arg3;
        logic [DATA_W-1:0] imm;
        logic [2:0]        rs1;
        logic [2:0]        rs2;
        logic [2:0]        rd;
    } idex_t;

    logic [DATA_W-1:0] r_rf [8];
    idex_t             r_idex;
    idex_t             w_dec;

    logic [3:0]        w_op;
    logic [2:0]        w_rd, w_rs1, w_rs2;
    logic [DATA_W-1:0] w_rd1, w_rd2, w_rd3;
    logic [DATA_W-1:0] w_cmp_a, w_cmp_b;
    logic              w_is_br, w_is_jal, w_uses_rs2, w_taken;
    logic              w_ex_lw, w_ex_wr, w_hazard;
    logic [PC_W-1:0]   w_off, w_target;

    assign w_op  = i_ir_in[3:0];
    assign w_rd  = i_ir_in[6:4];
    assign w_rs1 = i_ir_in[9:7];
    assign w_rs2 = i_ir_in[12:10];

    function automatic logic [DATA_W-1:0] rf_read(input logic [2:0] idx);
        logic [DATA_W-1:0] val;
        val = r_rf[idx];
`ifdef REGFILE_BYPASS_EN
        if (i_rf_write && (i_load_addr == idx)) val = i_load_data;
`endif
        if (idx == 3'd0) val = '0;
        return val;
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 8; i++) r_rf[i] <= '0;
        end else if (i_rf_write && (i_load_addr != 3'd0)) begin
            r_rf[i_load_addr] <= i_load_data;
        end
    end

    assign w_rd1 = rf_read(w_rs1);
    assign w_rd2 = rf_read(w_rs2);
    assign w_rd3 = rf_read(w_rd);

    assign w_is_br    = (w_op == OP_BEQ) || (w_op == OP_BNE);
    assign w_is_jal   = (w_op == OP_JAL);
    assign w_uses_rs2 = (w_op == OP_R) || (w_op == OP_SW) || w_is_br;

    assign w_cmp_a = i_fwd_sel1 ? i_fwd_data : w_rd1;
    assign w_cmp_b = i_fwd_sel2 ? i_fwd_data : w_rd2;
    assign w_taken = ((w_op == OP_BEQ) && (w_cmp_a == w_cmp_b)) ||
                     ((w_op == OP_BNE) && (w_cmp_a != w_cmp_b));

    // Offsets are halfword counts; the add wraps modulo 2^PC_W.
    assign w_off    = w_is_jal ? PC_W'($signed(i_ir_in[15:7]))
                               : PC_W'($signed({i_ir_in[15:13], i_ir_in[6:4]}));
    assign w_target = i_pc_in + (w_off << 1);

    assign w_ex_lw  = r_idex.valid && r_idex.mem_read && (r_idex.rd != 3'd0);
    assign w_ex_wr  = r_idex.valid && r_idex.reg_write && (r_idex.rd != 3'd0);
    assign w_hazard = i_id_valid && (
        (w_ex_lw && ((r_idex.rd == w_rs1) || (w_uses_rs2 && (r_idex.rd == w_rs2)))) ||
        (w_is_br && w_ex_wr && ((r_idex.rd == w_rs1) || (r_idex.rd == w_rs2))));

    assign o_stall_if = w_hazard || i_ex_stall;
    assign o_jump     = i_id_valid && !o_stall_if && (w_is_jal || w_taken);
    assign o_new_pc   = o_jump ? w_target : i_ipcp2;

    always_comb begin
        w_dec       = '0;
        w_dec.valid = 1'b1;
        w_dec.opcp2 = i_ipcp2;
        w_dec.arg1  = w_rd1;
        w_dec.arg2  = w_rd2;
        w_dec.arg3  = w_rd3;
        w_dec.rs1   = w_rs1;
        w_dec.rs2   = w_rs2;
        w_dec.rd    = w_rd;
        case (w_op)
            OP_R: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alu_op    = i_ir_in[15:13];
                w_dec.reg_store = 2'b01;
            end
            OP_I, OP_LW: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_op    = 3'b001;
                w_dec.imm       = DATA_W'($signed(i_ir_in[15:10]));
                w_dec.mem_read  = (w_op == OP_LW);
                w_dec.reg_store = (w_op == OP_LW) ? 2'b00 : 2'b01;
            end
            OP_SW: begin
                w_dec.alu_op    = 3'b001;
                w_dec.mem_write = 1'b1;
                w_dec.imm       = DATA_W'($signed(i_ir_in[15:10]));
            end
            OP_BEQ, OP_BNE: ;
            OP_JAL: begin
                w_dec.reg_write = 1'b1;
                w_dec.reg_store = 2'b10;
                w_dec.imm       = DATA_W'($signed(i_ir_in[15:7]));
            end
            default: w_dec = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idex <= '0;
        end else if (i_ex_stall) begin
            r_idex <= r_idex;
        end else if (w_hazard || !i_id_valid) begin
            r_idex <= '0;
        end else begin
            r_idex <= w_dec;
        end
    end

    assign o_reg_write = r_idex.reg_write;
    assign o_alu_src   = r_idex.alu_src;
    assign o_mem_write = r_idex.mem_write;
    assign o_mem_read  = r_idex.mem_read;
    assign o_valid     = r_idex.valid;
    assign o_alu_op    = r_idex.alu_op;
    assign o_reg_store = r_idex.reg_store;
    assign o_opcp2     = r_idex.opcp2;
    assign o_arg1      = r_idex.arg1;
    assign o_arg2      = r_idex.arg2;
    assign o_arg3      = r_idex.arg3;
    assign o_imm       = r_idex.imm;
    assign o_rs1       = r_idex.rs1;
    assign o_rs2       = r_idex.rs2;
    assign o_rd        = r_idex.rd;

endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
Parametrised next-generation decode stage for the 16-bit MISC-V pipeline. Holds the architectural register file and decodes one instruction per cycle. Resolves branches and jumps in ID using a forwarded comparator, and detects load-use and branch-operand hazards. Drives a registered ID/EX pipeline register with stall and bubble insertion.

Parameters:
DATA_W, 16, register/operand width (>=8)
PC_W, 16, program-counter width (>=8)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears regfile and all registered outputs
ir_in  in  16  instruction in ID
pc_in  in  PC_W  PC of ir_in
ipcp2  in  PC_W  pc_in+2 from IF
id_valid  in  1  ir_in is a real instruction
load_addr  in  3  writeback register index
load_data  in  DATA_W  writeback data
rf_write  in  1  writeback enable
fwd_sel1  in  1  1: comparator A takes fwd_data instead of rf[rs1]
fwd_sel2  in  1  1: comparator B takes fwd_data instead of rf[rs2]
fwd_data  in  DATA_W  forwarded value from EX/MEM
ex_stall  in  1  downstream hold request
reg_write, alu_src, mem_write, mem_read, valid  out  1 each  registered controls
alu_op  out  3  registered
reg_store  out  2  registered; 00 mem, 01 ALU, 10 PC+2
opcp2  out  PC_W  registered ipcp2
arg1, arg2, arg3, imm  out  DATA_W each  registered rf[rs1], rf[rs2], rf[rd], sign-extended immediate
rs1, rs2, rd  out  3 each  registered indices
stall_if  out  1  combinational; hold IF/ID
jump  out  1  combinational; redirect fetch
new_pc  out  PC_W  combinational; redirect target, otherwise ipcp2

Behaviour:
- Fields: op=ir[3:0], rd=ir[6:4], rs1=ir[9:7], rs2=ir[12:10].
- Regfile: 8 x DATA_W. x0 always reads 0. Write at posedge when rf_write and load_addr!=0. Reset zeroes all entries.
- Decode by op (any control not listed is 0):
  - 0000 R: reg_write=1, alu_src=1, alu_op=ir[15:13], reg_store=01.
  - 0001 I: reg_write=1, alu_op=001, reg_store=01, imm=sext(ir[15:10]).
  - 0010 LW: as I, but mem_read=1, reg_store=00.
  - 0011 SW: alu_op=001, mem_write=1, imm=sext(ir[15:10]).
  - 0100 BEQ / 0101 BNE: no writes; offset=sext({ir[15:13],ir[6:4]}).
  - 0110 JAL: reg_write=1, reg_store=10, offset=sext(ir[15:7]); imm carries the offset.
  - Any other op: bubble, i.e. all controls 0 and valid=0.
- Comparator: A = fwd_sel1 ? fwd_data : rf[rs1]; B = fwd_sel2 ? fwd_data : rf[rs2]. BEQ is taken when A==B; BNE is taken when A!=B.
- Target: pc_in + (offset<<1), modulo 2^PC_W (wraps).
- hazard is 1 when id_valid and either of:
  - EX holds a valid LW with rd_q!=0, and rd_q matches rs1 (any op), or rs2 (R/SW/BEQ/BNE).
  - op is BEQ/BNE and EX holds a valid reg_write with rd_q!=0 matching rs1 or rs2.
- Outputs:
  - stall_if = hazard | ex_stall.
  - jump = id_valid & ~stall_if & (JAL | taken branch).
  - new_pc = jump ? target : ipcp2.
- Pipeline register, priority order:
  1. reset: all outputs 0.
  2. ex_stall: hold every output.
  3. hazard or ~id_valid: load a bubble (controls, valid, rs/rd all 0; data fields don't-care, driven 0).
  4. Otherwise capture the decode result, valid=1.
- Latency: one clock from ir_in to registered outputs. Throughput: one instruction per cycle absent stalls.
- Flush of IF/ID after a jump is IF's job; this block only raises jump for one cycle per accepted instruction.
- Reset asserted mid-stall clears everything immediately; the first cycle after release sees an empty EX (no hazard).

Optional Feature:
REGFILE_BYPASS_EN
- Defined: a read of register r in the same cycle as a writeback to r (r!=0) returns load_data. This applies to arg1-3 and to the comparator's non-forwarded inputs.
- Undefined: such a read returns the old value; the external forwarding unit must cover that case.

Test Plan:
- Reset, then write x5=16, x6=10, x4=-8; decode R 0x1D60 (rd=6, rs1=2, rs2=7) after loading x2=3, x7=4 -> next cycle reg_write=1, alu_src=1, arg1=3, arg2=4, valid=1, jump=0.
- I-type with ir[15:10]=6'b111000, rs1=x5 -> imm=-8, alu_op=001, reg_store=01, arg1=16.
- LW rd=x3 followed by R using rs1=x3 -> stall_if=1 for one cycle, bubble (valid=0) enters EX, then the R instruction issues.
- BEQ x5,x5 offset -2, pc_in=0x0010 -> jump=1, new_pc=0x000C. Same instruction with fwd_sel2=1, fwd_data=0 -> jump=0, new_pc=ipcp2.
- JAL offset -1 with pc_in=0x0000 -> new_pc=0xFFFE (wrap), reg_store=10, opcp2=ipcp2.
- ex_stall=1 for 2 cycles mid-stream -> outputs unchanged, stall_if=1, jump=0. Reset asserted during the stall -> all outputs 0 asynchronously.
